// File: rtl/peripheral_dsa_pkg.sv
// Shared constants and FSM encoding for the DSA signature datapath.
// Consumed by peripheral_dsa_signature_r and its reduction step.
package peripheral_dsa_pkg;

    localparam int DATA_SIZE = 32;
    localparam int CNT_W     = $clog2(DATA_SIZE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/peripheral_dsa_cond_sub.sv
// One restoring-reduction step: shift in a bit of x,
// then subtract n when the shifted remainder reaches it.
module peripheral_dsa_cond_sub #(
    parameter int DATA_SIZE = peripheral_dsa_pkg::DATA_SIZE
) (
    input  logic [DATA_SIZE-1:0] rem_in,
    input  logic                 bit_in,
    input  logic [DATA_SIZE-1:0] modulus,
    output logic [DATA_SIZE:0]   rem_out
);

    logic [DATA_SIZE:0] t;
    logic [DATA_SIZE:0] n_ext;

    always_comb begin
        t       = {rem_in, bit_in};
        n_ext   = {1'b0, modulus};
        rem_out = (t >= n_ext) ? (t - n_ext) : t;
    end

endmodule

// File: rtl/peripheral_dsa_signature_r.sv
// r = x mod n by bit-serial restoring reduction, flags r == 0 and n == 0.
// Build option: PERIPHERAL_DSA_SIGNATURE_R_FAST_EN bypasses reduction when x < n.
module peripheral_dsa_signature_r #(
    parameter int DATA_SIZE = peripheral_dsa_pkg::DATA_SIZE
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [DATA_SIZE-1:0] POINT_IN_X,
    input  logic [DATA_SIZE-1:0] POINT_IN_Y,
    input  logic [DATA_SIZE-1:0] MODULUS_N,
    output logic                 READY,
    output logic                 BUSY,
    output logic [DATA_SIZE-1:0] SIGNATURE_R,
    output logic [DATA_SIZE-1:0] POINT_OUT_Y,
    output logic                 R_ZERO,
    output logic                 ERROR
);

    import peripheral_dsa_pkg::*;

    localparam int CW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [DATA_SIZE-1:0] x_q;
    logic [DATA_SIZE-1:0] n_q;
    logic [DATA_SIZE-1:0] rem;
    logic [DATA_SIZE:0]   rem_nxt;

    // rem stays below n, so only the low DATA_SIZE bits need storage
    peripheral_dsa_cond_sub #(
        .DATA_SIZE(DATA_SIZE)
    ) u_step (
        .rem_in (rem),
        .bit_in (x_q[cnt]),
        .modulus(n_q),
        .rem_out(rem_nxt)
    );

    assign READY = (state == DONE);
    assign BUSY  = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            cnt         <= '0;
            x_q         <= '0;
            n_q         <= '0;
            rem         <= '0;
            SIGNATURE_R <= '0;
            POINT_OUT_Y <= '0;
            R_ZERO      <= 1'b0;
            ERROR       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (START) begin
                        x_q         <= POINT_IN_X;
                        n_q         <= MODULUS_N;
                        POINT_OUT_Y <= POINT_IN_Y;
                        rem         <= '0;
                        SIGNATURE_R <= '0;
                        R_ZERO      <= 1'b0;
                        ERROR       <= 1'b0;
                        if (MODULUS_N == '0) begin
                            ERROR <= 1'b1;
                            state <= DONE;
                        end
`ifdef PERIPHERAL_DSA_SIGNATURE_R_FAST_EN
                        else if (POINT_IN_X < MODULUS_N) begin
                            rem         <= POINT_IN_X;
                            SIGNATURE_R <= POINT_IN_X;
                            R_ZERO      <= (POINT_IN_X == '0);
                            state       <= DONE;
                        end
`endif
                        else begin
                            cnt   <= CW'(DATA_SIZE - 1);
                            state <= REDUCE;
                        end
                    end
                end
                REDUCE: begin
                    rem <= rem_nxt[DATA_SIZE-1:0];
                    if (cnt == '0) begin
                        SIGNATURE_R <= rem_nxt[DATA_SIZE-1:0];
                        R_ZERO      <= (rem_nxt == '0);
                        state       <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_dsa_signature_r.sv
// Randomised self-checking bench for peripheral_dsa_signature_r.
// Reference: r = x % n, latency from operand values and build option.
module tb_peripheral_dsa_signature_r;

    localparam int N = 32;
`ifdef PERIPHERAL_DSA_SIGNATURE_R_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RST;
    logic         START;
    logic [N-1:0] POINT_IN_X;
    logic [N-1:0] POINT_IN_Y;
    logic [N-1:0] MODULUS_N;
    logic         READY;
    logic         BUSY;
    logic [N-1:0] SIGNATURE_R;
    logic [N-1:0] POINT_OUT_Y;
    logic         R_ZERO;
    logic         ERROR;

    int checks = 0;
    int errors = 0;

    int           lat;
    logic [N-1:0] g_sig;
    logic [N-1:0] g_y;
    logic         g_rz;
    logic         g_err;
    logic         g_busy_ok;
    logic         g_ready_after;

    peripheral_dsa_signature_r #(.DATA_SIZE(N)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .POINT_IN_X (POINT_IN_X),
        .POINT_IN_Y (POINT_IN_Y),
        .MODULUS_N  (MODULUS_N),
        .READY      (READY),
        .BUSY       (BUSY),
        .SIGNATURE_R(SIGNATURE_R),
        .POINT_OUT_Y(POINT_OUT_Y),
        .R_ZERO     (R_ZERO),
        .ERROR      (ERROR)
    );

    always #5 CLK = ~CLK;

    function automatic logic [N-1:0] ref_r(logic [N-1:0] x, logic [N-1:0] n);
        if (n == 0) return '0;
        return x % n;
    endfunction

    function automatic int exp_lat(logic [N-1:0] x, logic [N-1:0] n);
        if (n == 0) return 1;
        if (FAST && x < n) return 1;
        return N + 1;
    endfunction

    // Launch one operation from IDLE and capture the READY-cycle outputs.
    task automatic op(input logic [N-1:0] x, input logic [N-1:0] y,
                      input logic [N-1:0] n);
        @(negedge CLK);
        POINT_IN_X = x;
        POINT_IN_Y = y;
        MODULUS_N  = n;
        START      = 1'b1;
        lat        = -1;
        g_busy_ok  = 1'b1;
        for (int c = 1; c <= N + 20; c++) begin
            @(negedge CLK);
            START = 1'b0;
            if (!BUSY) g_busy_ok = 1'b0;
            if (READY) begin
                lat = c;
                break;
            end
        end
        g_sig = SIGNATURE_R;
        g_y   = POINT_OUT_Y;
        g_rz  = R_ZERO;
        g_err = ERROR;
        @(negedge CLK);
        g_ready_after = READY;
    endtask

    task automatic test_reset();
        RST        = 1'b1;
        START      = 1'b1;
        POINT_IN_X = 32'd5;
        POINT_IN_Y = 32'd9;
        MODULUS_N  = 32'd7;
        repeat (3) @(negedge CLK);
        RST   = 1'b0;
        START = 1'b0;
        checks++;
        if (READY !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl got ready=%b busy=%b want 0 0", READY, BUSY);
        end
        checks++;
        if (SIGNATURE_R !== '0 || POINT_OUT_Y !== '0) begin
            errors++;
            $display("FAIL reset_data got r=%0h y=%0h want 0 0", SIGNATURE_R, POINT_OUT_Y);
        end
        checks++;
        if (R_ZERO !== 1'b0 || ERROR !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got rz=%b err=%b want 0 0", R_ZERO, ERROR);
        end
        @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0) begin
            errors++;
            $display("FAIL start_with_rst got busy=%b want 0", BUSY);
        end
    endtask

    task automatic test_basic();
        op(32'd100, 32'hBEEF, 32'd7);
        checks++;
        if (lat !== exp_lat(32'd100, 32'd7)) begin
            errors++;
            $display("FAIL basic_lat got %0d want %0d", lat, exp_lat(32'd100, 32'd7));
        end
        checks++;
        if (g_sig !== 32'd2 || g_rz !== 1'b0 || g_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_res got r=%0d rz=%b err=%b want 2 0 0", g_sig, g_rz, g_err);
        end
        checks++;
        if (g_busy_ok !== 1'b1 || g_ready_after !== 1'b0) begin
            errors++;
            $display("FAIL basic_hs got busy_ok=%b rdy_after=%b want 1 0", g_busy_ok, g_ready_after);
        end
        checks++;
        if (g_y !== 32'hBEEF) begin
            errors++;
            $display("FAIL basic_y got %0h want beef", g_y);
        end
    endtask

    task automatic test_boundaries();
        op(32'd6, 32'd1, 32'd7);
        checks++;
        if (g_sig !== 32'd6 || g_rz !== 1'b0 || lat !== exp_lat(32'd6, 32'd7)) begin
            errors++;
            $display("FAIL below_n got r=%0d rz=%b lat=%0d want 6 0 %0d",
                     g_sig, g_rz, lat, exp_lat(32'd6, 32'd7));
        end
        op(32'd7, 32'd2, 32'd7);
        checks++;
        if (g_sig !== 32'd0 || g_rz !== 1'b1 || lat !== N + 1) begin
            errors++;
            $display("FAIL equal_n got r=%0d rz=%b lat=%0d want 0 1 %0d", g_sig, g_rz, lat, N + 1);
        end
        op('1, 32'd3, 32'd1);
        checks++;
        if (g_sig !== 32'd0 || g_rz !== 1'b1 || g_err !== 1'b0) begin
            errors++;
            $display("FAIL ones_mod1 got r=%0d rz=%b err=%b want 0 1 0", g_sig, g_rz, g_err);
        end
        op('1, 32'd4, 32'hFFFF_FFFE);
        checks++;
        if (g_sig !== 32'd1 || g_rz !== 1'b0) begin
            errors++;
            $display("FAIL ones_big got r=%0d rz=%b want 1 0", g_sig, g_rz);
        end
    endtask

    task automatic test_error();
        op(32'd5, 32'd7, 32'd0);
        checks++;
        if (lat !== 1 || g_err !== 1'b1 || g_sig !== 32'd0 || g_rz !== 1'b0) begin
            errors++;
            $display("FAIL n_zero got lat=%0d err=%b r=%0d rz=%b want 1 1 0 0",
                     lat, g_err, g_sig, g_rz);
        end
        op(32'd10, 32'd8, 32'd3);
        checks++;
        if (g_err !== 1'b0 || g_sig !== 32'd1 || lat !== N + 1) begin
            errors++;
            $display("FAIL after_err got err=%b r=%0d lat=%0d want 0 1 %0d", g_err, g_sig, lat, N + 1);
        end
    endtask

    task automatic test_back_to_back();
        int           readies;
        int           first;
        logic [N-1:0] s;
        logic [N-1:0] y;
        readies = 0;
        first   = -1;
        s       = '0;
        y       = '0;
        @(negedge CLK);
        POINT_IN_X = 32'd100;
        POINT_IN_Y = 32'hAAAA;
        MODULUS_N  = 32'd7;
        START      = 1'b1;
        for (int c = 1; c <= 2 * N + 10; c++) begin
            @(negedge CLK);
            START = 1'b0;
            if (c == 3) begin
                POINT_IN_X = 32'd9;
                POINT_IN_Y = 32'h5555;
                START      = 1'b1;
            end
            if (READY) begin
                readies++;
                if (first < 0) begin
                    first = c;
                    s     = SIGNATURE_R;
                    y     = POINT_OUT_Y;
                end
            end
        end
        checks++;
        if (readies !== 1 || first !== N + 1) begin
            errors++;
            $display("FAIL b2b_ready got n=%0d at=%0d want 1 %0d", readies, first, N + 1);
        end
        checks++;
        if (s !== 32'd2 || y !== 32'hAAAA) begin
            errors++;
            $display("FAIL b2b_res got r=%0d y=%0h want 2 aaaa", s, y);
        end
    endtask

    task automatic test_reset_abort();
        int readies;
        readies = 0;
        @(negedge CLK);
        POINT_IN_X = 32'd100;
        POINT_IN_Y = 32'h1234;
        MODULUS_N  = 32'd7;
        START      = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checks++;
        if (READY !== 1'b0 || BUSY !== 1'b0 || POINT_OUT_Y !== '0 ||
            SIGNATURE_R !== '0 || R_ZERO !== 1'b0 || ERROR !== 1'b0) begin
            errors++;
            $display("FAIL abort_outs got rdy=%b busy=%b y=%0h r=%0h rz=%b err=%b want all 0",
                     READY, BUSY, POINT_OUT_Y, SIGNATURE_R, R_ZERO, ERROR);
        end
        for (int c = 0; c < N + 5; c++) begin
            @(negedge CLK);
            if (READY || BUSY) readies++;
        end
        checks++;
        if (readies !== 0) begin
            errors++;
            $display("FAIL abort_idle got %0d active cycles want 0", readies);
        end
        op(32'd20, 32'd6, 32'd6);
        checks++;
        if (g_sig !== 32'd2 || lat !== N + 1) begin
            errors++;
            $display("FAIL abort_next got r=%0d lat=%0d want 2 %0d", g_sig, lat, N + 1);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic [N-1:0] n;
        logic [N-1:0] r;
        int           mode;
        for (int i = 0; i < 40; i++) begin
            x    = $urandom;
            y    = $urandom;
            mode = $urandom_range(0, 7);
            case (mode)
                0, 1: n = $urandom;
                2, 3: n = $urandom_range(1, 20);
                4:    n = x + $urandom_range(1, 100);
                5:    begin x = $urandom_range(0, 50); n = $urandom_range(1, 60); end
                6:    n = x;
                default: n = '0;
            endcase
            r = ref_r(x, n);
            op(x, y, n);
            checks++;
            if (g_sig !== r || g_rz !== (n != 0 && r == 0) || g_err !== (n == 0)) begin
                errors++;
                $display("FAIL rand_res x=%0h n=%0h got r=%0h rz=%b err=%b want r=%0h",
                         x, n, g_sig, g_rz, g_err, r);
            end
            checks++;
            if (lat !== exp_lat(x, n) || g_y !== y || g_busy_ok !== 1'b1) begin
                errors++;
                $display("FAIL rand_hs x=%0h n=%0h got lat=%0d y=%0h busy_ok=%b want lat=%0d y=%0h",
                         x, n, lat, g_y, g_busy_ok, exp_lat(x, n), y);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_error();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
